// File: rtl/tinyriscv_pkg.sv
// Shared tinyriscv definitions: bus widths, rib responder states
// and the rib_timer register map.
package tinyriscv_pkg;

  localparam int MemAddrBus = 32;
  localparam int MemBus     = 32;

  typedef enum logic [1:0] {
    REG_CTRL  = 2'd0,
    REG_VALUE = 2'd1,
    REG_CMP   = 2'd2
  } rib_timer_reg_e;

  localparam int CtrlEnBit    = 0;
  localparam int CtrlIntEnBit = 1;
  localparam int CtrlPendBit  = 2;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_RESP = 2'd2
  } rib_resp_state_e;

endpackage

// File: rtl/rib_resp_fsm.sv
// Wait-state handshake engine for rib responders: latches a request,
// counts wait states and emits ready/commit/capture strobes.
module rib_resp_fsm
  import tinyriscv_pkg::*;
#(
  parameter int unsigned WaitCycles = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [MemAddrBus-1:0] i_addr,
  input  logic [MemBus-1:0]     i_wdata,
  output logic                  o_ready,
  output logic                  o_commit,
  output logic                  o_capture,
  output logic                  o_we,
  output logic [MemAddrBus-1:0] o_addr,
  output logic [MemBus-1:0]     o_wdata,
  output logic                  o_cap_we,
  output logic [MemAddrBus-1:0] o_cap_addr
);

  localparam logic [3:0] WaitInit = 4'(WaitCycles);

  rib_resp_state_e       r_state;
  logic [3:0]            r_wcnt;
  logic                  r_we;
  logic [MemAddrBus-1:0] r_addr;
  logic [MemBus-1:0]     r_wdata;
  logic                  r_ready;
  logic                  w_to_resp;

  always_comb begin
    w_to_resp = 1'b0;
    unique case (r_state)
      RS_IDLE: w_to_resp = i_req && (WaitCycles == 0);
      RS_WAIT: w_to_resp = i_req && (r_wcnt == 4'd1);
      default: w_to_resp = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RS_IDLE;
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_to_resp;
      unique case (r_state)
        RS_IDLE: begin
          if (i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wcnt  <= WaitInit;
            r_state <= (WaitCycles == 0) ? RS_RESP : RS_WAIT;
          end
        end
        RS_WAIT: begin
          // a dropped request abandons the access silently
          if (!i_req)
            r_state <= RS_IDLE;
          else if (r_wcnt == 4'd1)
            r_state <= RS_RESP;
          else
            r_wcnt <= r_wcnt - 4'd1;
        end
        RS_RESP: r_state <= RS_IDLE;
        default: r_state <= RS_IDLE;
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_commit   = (r_state == RS_RESP);
  assign o_capture  = w_to_resp;
  assign o_we       = r_we;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_cap_we   = (r_state == RS_IDLE) ? i_we : r_we;
  assign o_cap_addr = (r_state == RS_IDLE) ? i_addr : r_addr;

endmodule

// File: rtl/rib_timer.sv
// Memory-mapped rib timer: free-running counter with compare match,
// write-1-to-clear pending flag and a level interrupt.
module rib_timer
  import tinyriscv_pkg::*;
#(
  parameter int unsigned WaitCycles = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [MemAddrBus-1:0] addr_i,
  input  logic [MemBus-1:0]     data_i,
  output logic [MemBus-1:0]     data_o,
  output logic                  ready_o,
  output logic                  int_o
);

  logic                  w_commit;
  logic                  w_capture;
  logic                  w_we;
  logic [MemAddrBus-1:0] w_addr;
  logic [MemBus-1:0]     w_wdata;
  logic                  w_cap_we;
  logic [MemAddrBus-1:0] w_cap_addr;
  logic                  w_unused;

  rib_resp_fsm #(
    .WaitCycles(WaitCycles)
  ) u_fsm (
    .i_clk     (clk_i),
    .i_rst_n   (rst_ni),
    .i_req     (req_i),
    .i_we      (we_i),
    .i_addr    (addr_i),
    .i_wdata   (data_i),
    .o_ready   (ready_o),
    .o_commit  (w_commit),
    .o_capture (w_capture),
    .o_we      (w_we),
    .o_addr    (w_addr),
    .o_wdata   (w_wdata),
    .o_cap_we  (w_cap_we),
    .o_cap_addr(w_cap_addr)
  );

  assign w_unused = ^{w_addr[MemAddrBus-1:4], w_addr[1:0],
                      w_cap_addr[MemAddrBus-1:4], w_cap_addr[1:0]};

  logic              r_en;
  logic              r_int_en;
  logic              r_pending;
  logic              r_int;
  logic [MemBus-1:0] r_value;
  logic [MemBus-1:0] r_cmp;
  logic [MemBus-1:0] r_rdata;

  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_value;
  logic              w_wr_cmp;
  logic              w_match;
  logic              w_en_nxt;
  logic              w_int_en_nxt;
  logic              w_pend_nxt;
  logic [MemBus-1:0] w_value_nxt;
  logic [1:0]        w_sel;
  logic [MemBus-1:0] w_rd_mux;

  assign w_wr       = w_commit & w_we;
  assign w_wr_ctrl  = w_wr & (w_addr[3:2] == REG_CTRL);
  assign w_wr_value = w_wr & (w_addr[3:2] == REG_VALUE);
  assign w_wr_cmp   = w_wr & (w_addr[3:2] == REG_CMP);
  assign w_match    = r_en & (r_value == r_cmp);

  assign w_en_nxt     = w_wr_ctrl ? w_wdata[CtrlEnBit] : r_en;
  assign w_int_en_nxt = w_wr_ctrl ? w_wdata[CtrlIntEnBit] : r_int_en;
  // a match in the same cycle as a W1C keeps pending set
  assign w_pend_nxt   = w_match |
                        (r_pending & ~(w_wr_ctrl & w_wdata[CtrlPendBit]));

  always_comb begin
    w_value_nxt = r_value;
    if (w_wr_value)
      w_value_nxt = w_wdata;
    else if (w_match)
      w_value_nxt = '0;
    else if (r_en)
      w_value_nxt = r_value + 32'd1;
  end

  assign w_sel = w_cap_addr[3:2];

  always_comb begin
    w_rd_mux = '0;
    unique case (1'b1)
      (w_sel == REG_CTRL):
        w_rd_mux = {29'd0, r_pending, r_int_en, r_en};
      (w_sel == REG_VALUE): w_rd_mux = r_value;
      (w_sel == REG_CMP):   w_rd_mux = r_cmp;
      default:              w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en      <= 1'b0;
      r_int_en  <= 1'b0;
      r_pending <= 1'b0;
      r_int     <= 1'b0;
      r_value   <= '0;
      r_cmp     <= 32'hFFFF_FFFF;
      r_rdata   <= '0;
    end else begin
      r_en      <= w_en_nxt;
      r_int_en  <= w_int_en_nxt;
      r_pending <= w_pend_nxt;
      r_int     <= w_pend_nxt & w_int_en_nxt;
      r_value   <= w_value_nxt;
      if (w_wr_cmp)
        r_cmp <= w_wdata;
      r_rdata <= (w_capture && !w_cap_we) ? w_rd_mux : '0;
    end
  end

  assign data_o = r_rdata;
  assign int_o  = r_int;

endmodule

// File: tb/tb_rib_timer.sv
// Directed bench for rib_timer with WaitCycles of 1, 3 and 0.
module tb_rib_timer;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        intr  [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rib_timer #(.WaitCycles(1)) u_w1 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .data_i(wdata[0]), .data_o(rdata[0]),
    .ready_o(ready[0]), .int_o(intr[0]));

  rib_timer #(.WaitCycles(3)) u_w3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .data_i(wdata[1]), .data_o(rdata[1]),
    .ready_o(ready[1]), .int_o(intr[1]));

  rib_timer #(.WaitCycles(0)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .we_i(we[2]),
    .addr_i(addr[2]), .data_i(wdata[2]), .data_o(rdata[2]),
    .ready_o(ready[2]), .int_o(intr[2]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // issue at a negedge; returns one negedge after the RESP cycle
  task automatic bus(input int i, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output int lat);
    bit got;
    got = 0;
    rd  = '0;
    lat = 0;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (ready[i]) begin
        rd  = rdata[i];
        got = 1;
        break;
      end
      chk("data_idle", rdata[i], 32'd0);
    end
    if (!got) chk("ready_timeout", {31'd0, ready[i]}, 32'd1);
    req[i] = 1'b0; we[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_phase(input int c0, input int want);
    for (int k = 0; k < 7; k++) begin
      if (((cyc + 3 - c0) % 6) == want) break;
      @(negedge clk);
    end
  endtask

  logic [31:0] rd;
  int          lat;
  int          c0;
  int          x;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    chk("rst_ready", {31'd0, ready[0]}, 32'd0);
    chk("rst_data", rdata[0], 32'd0);
    chk("rst_int", {31'd0, intr[0]}, 32'd0);

    bus(0, 1'b0, 32'h8, 32'd0, rd, lat);
    chk("rst_cmp", rd, 32'hFFFF_FFFF);
    chk("lat_w1", lat, 32'd2);
    bus(0, 1'b0, 32'h4, 32'd0, rd, lat);
    chk("rst_value", rd, 32'd0);
    bus(0, 1'b0, 32'h0, 32'd0, rd, lat);
    chk("rst_ctrl", rd, 32'd0);

    bus(0, 1'b1, 32'h8, 32'd5, rd, lat);
    bus(0, 1'b1, 32'h0, 32'h3, rd, lat);
    c0 = cyc;
    repeat (5) @(negedge clk);
    chk("int_before_match", {31'd0, intr[0]}, 32'd0);
    @(negedge clk);
    chk("int_after_match", {31'd0, intr[0]}, 32'd1);

    bus(0, 1'b0, 32'h0, 32'd0, rd, lat);
    chk("ctrl_pending", rd, 32'h7);
    x = cyc;
    bus(0, 1'b0, 32'h4, 32'd0, rd, lat);
    chk("value_wrap", rd, 32'((x + 1 - c0) % 6));

    wait_phase(c0, 3);
    bus(0, 1'b1, 32'h0, 32'h7, rd, lat);
    chk("int_cleared", {31'd0, intr[0]}, 32'd0);
    bus(0, 1'b0, 32'h0, 32'd0, rd, lat);
    chk("ctrl_cleared", rd, 32'h3);

    wait_phase(c0, 0);
    bus(0, 1'b1, 32'h0, 32'h7, rd, lat);
    chk("int_set_wins", {31'd0, intr[0]}, 32'd1);
    bus(0, 1'b0, 32'h0, 32'd0, rd, lat);
    chk("ctrl_set_wins", rd, 32'h7);

    wait_phase(c0, 0);
    bus(0, 1'b1, 32'h4, 32'h100, rd, lat);
    bus(0, 1'b0, 32'h4, 32'd0, rd, lat);
    chk("write_beats_inc", rd, 32'h101);

    bus(1, 1'b1, 32'h8, 32'h55, rd, lat);
    bus(1, 1'b0, 32'h8, 32'd0, rd, lat);
    chk("cmp_w3", rd, 32'h55);
    chk("lat_w3", lat, 32'd4);

    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h4; wdata[1] = 32'h77;
    repeat (2) begin
      @(negedge clk);
      chk("abort_wait_ready", {31'd0, ready[1]}, 32'd0);
    end
    req[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_ready", {31'd0, ready[1]}, 32'd0);
    end
    bus(1, 1'b0, 32'h4, 32'd0, rd, lat);
    chk("abort_value", rd, 32'd0);

    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h99;
    repeat (3) @(negedge clk);
    req[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort2_ready", {31'd0, ready[1]}, 32'd0);
    end
    bus(1, 1'b0, 32'h8, 32'd0, rd, lat);
    chk("abort_cmp", rd, 32'h55);

    bus(1, 1'b1, 32'h0, 32'h3, rd, lat);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h12;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, ready[1]}, 32'd0);
    req[1] = 1'b0; we[1] = 1'b0;
    rst_n[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_ready", {31'd0, ready[1]}, 32'd0);
    end
    bus(1, 1'b0, 32'h8, 32'd0, rd, lat);
    chk("mid_rst_cmp", rd, 32'hFFFF_FFFF);
    bus(1, 1'b0, 32'h0, 32'd0, rd, lat);
    chk("mid_rst_ctrl", rd, 32'd0);
    bus(1, 1'b0, 32'h4, 32'd0, rd, lat);
    chk("mid_rst_value", rd, 32'd0);

    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'hC;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_ready", {31'd0, ready[2]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b_data", rdata[2], 32'd0);
    end
    req[2] = 1'b0;
    @(negedge clk);
    bus(2, 1'b1, 32'hC, 32'hDEAD_BEEF, rd, lat);
    chk("lat_w0", lat, 32'd1);
    bus(2, 1'b0, 32'h8, 32'd0, rd, lat);
    chk("off3_cmp", rd, 32'hFFFF_FFFF);
    bus(2, 1'b0, 32'h4, 32'd0, rd, lat);
    chk("off3_value", rd, 32'd0);
    bus(2, 1'b0, 32'h0, 32'd0, rd, lat);
    chk("off3_ctrl", rd, 32'd0);
    bus(2, 1'b1, 32'h8, 32'h1234, rd, lat);
    bus(2, 1'b0, 32'h8, 32'd0, rd, lat);
    chk("w0_cmp", rd, 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
